autoconfig_ctrl: RTL and testbench

AUTOCONFIG_CTRL -- requirements
Module: autoconfig_ctrl

---
 rtl/autoconfig_ctrl.sv | 88 ++++++++
 tb/tb_autoconfig_ctrl.sv | 124 ++++++++++++
 2 files changed

// File: rtl/autoconfig_ctrl.sv
// autoconfig_ctrl: Zorro II autoconfig sequencer for a FastRAM board followed by an IDE board,
// with registered chip selects for the configured boards.
module autoconfig_ctrl (
  input  logic        CPU_CLK,
  input  logic        RESET,
  input  logic        CPU_AS,
  input  logic        RW,
  input  logic        UDS,
  input  logic [23:1] A,
  input  logic [3:0]  D_IN,
  output logic [3:0]  D_OUT,
  output logic        D_OE,
  output logic        INTERNAL_CYCLE,
  output logic        RAM_CE,
  output logic        IDE_CE,
  output logic [1:0]  CFG_STATE
);
  typedef enum logic [1:0] {CFG_RAM = 2'b00, CFG_IDE = 2'b01, DONE = 2'b10} state_t;
  state_t      state, state_nx;
  logic [1:0]  ram_base;
  logic [7:0]  ide_base;
  logic [3:0]  pend;
  logic        ram_cfg, ide_cfg, oneshot;
  logic [7:0]  offset, byte_val;
  logic [3:0]  nib;
  logic        ram_hit, ide_hit, ac_hit, ac_rd, wr;
  logic        unused;
  assign unused    = ^A[15:8];
  assign offset    = {A[7:1], 1'b0};
  assign ram_hit   = ram_cfg && A[23:22] == ram_base;
  assign ide_hit   = ide_cfg && A[23:16] == ide_base && !ram_hit;
  assign ac_hit    = A[23:16] == 8'hE8 && state != DONE && !ram_hit && !ide_hit;
  assign ac_rd     = !CPU_AS && ac_hit && RW;
  assign wr        = !CPU_AS && !RW && !UDS && ac_hit && !oneshot;
  assign CFG_STATE = state;
  always_comb begin
    byte_val = 8'h00;
    case (offset[5:2])
      4'd0: byte_val = state == CFG_RAM ? 8'hE7 : 8'hC1;
      4'd1: byte_val = state == CFG_RAM ? 8'h01 : 8'h02;
      4'd2: byte_val = state == CFG_RAM ? 8'hC0 : 8'h00;
      4'd4: byte_val = 8'h07;
      4'd5: byte_val = 8'hDB;
      default: byte_val = 8'h00;
    endcase
    // only byte 0 is presented true; the rest of the ROM reads inverted
    if (offset[5:2] != 4'd0) byte_val = ~byte_val;
    nib = offset[7:6] != 2'b00 ? 4'hF : offset[1] ? byte_val[3:0] : byte_val[7:4];
  end
  always_comb begin
    state_nx = state;
    if (wr && (offset == 8'h48 || offset == 8'h4C))
      state_nx = state == CFG_RAM ? CFG_IDE : DONE;
  end
  always_ff @(posedge CPU_CLK or negedge RESET)
    if (!RESET) state <= CFG_RAM;
    else        state <= state_nx;
  always_ff @(posedge CPU_CLK or negedge RESET)
    if (!RESET) begin
      ram_base       <= 2'b00;
      ide_base       <= 8'h00;
      pend           <= 4'h0;
      ram_cfg        <= 1'b0;
      ide_cfg        <= 1'b0;
      oneshot        <= 1'b0;
      RAM_CE         <= 1'b1;
      IDE_CE         <= 1'b1;
      INTERNAL_CYCLE <= 1'b1;
      D_OE           <= 1'b0;
      D_OUT          <= 4'hF;
    end else begin
      oneshot <= CPU_AS ? 1'b0 : oneshot | wr;
      if (wr && offset == 8'h48 && state == CFG_RAM) begin
        ram_base <= D_IN[3:2];
        ram_cfg  <= 1'b1;
      end
      if (wr && offset == 8'h4A && state == CFG_IDE) pend <= D_IN;
      if (wr && offset == 8'h48 && state == CFG_IDE) begin
        ide_base <= {D_IN, pend};
        ide_cfg  <= 1'b1;
      end
      RAM_CE         <= CPU_AS | !ram_hit;
      IDE_CE         <= CPU_AS | !ide_hit;
      INTERNAL_CYCLE <= CPU_AS | !(ram_hit | ide_hit | ac_hit);
      D_OE           <= ac_rd;
      D_OUT          <= ac_rd ? nib : 4'hF;
    end
endmodule

// File: tb/tb_autoconfig_ctrl.sv
// tb_autoconfig_ctrl: directed scoreboard bench for autoconfig_ctrl.
module tb_autoconfig_ctrl;
  logic        CPU_CLK, RESET, CPU_AS, RW, UDS;
  logic [23:1] A;
  logic [3:0]  D_IN, D_OUT;
  logic        D_OE, INTERNAL_CYCLE, RAM_CE, IDE_CE;
  logic [1:0]  CFG_STATE;
  typedef struct { string tag; logic [9:0] v; } exp_t;
  exp_t sb[$];
  int   n_tests = 0, n_fail = 0;
  autoconfig_ctrl dut (
    .CPU_CLK(CPU_CLK), .RESET(RESET), .CPU_AS(CPU_AS), .RW(RW), .UDS(UDS), .A(A),
    .D_IN(D_IN), .D_OUT(D_OUT), .D_OE(D_OE), .INTERNAL_CYCLE(INTERNAL_CYCLE),
    .RAM_CE(RAM_CE), .IDE_CE(IDE_CE), .CFG_STATE(CFG_STATE)
  );
  initial CPU_CLK = 1'b0;
  always #5 CPU_CLK = ~CPU_CLK;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end
  task automatic push(input string tag, input logic [3:0] d, input logic oe, input logic ic,
                      input logic rc, input logic dc, input logic [1:0] st);
    exp_t e;
    e.tag = tag;
    e.v   = {d, oe, ic, rc, dc, st};
    sb.push_back(e);
  endtask
  task automatic check();
    exp_t       e;
    logic [9:0] obs;
    obs = {D_OUT, D_OE, INTERNAL_CYCLE, RAM_CE, IDE_CE, CFG_STATE};
    n_tests++;
    if (sb.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_empty observed=%h expected=<entry>", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.v) else begin
        n_fail++;
        $error("FAIL %s observed={dout,oe,ic,ram,ide,st}=%h expected=%h", e.tag, obs, e.v);
      end
    end
  endtask
  task automatic cyc(input logic [23:0] addr, input logic rw, input logic [3:0] d, input string tag,
                     input logic [3:0] ed, input logic eoe, input logic eic, input logic erc,
                     input logic edc, input logic [1:0] est);
    @(negedge CPU_CLK);
    A = addr[23:1]; RW = rw; D_IN = d; UDS = 1'b0; CPU_AS = 1'b0;
    push(tag, ed, eoe, eic, erc, edc, est);
    @(posedge CPU_CLK); #1 check();
    @(negedge CPU_CLK);
    CPU_AS = 1'b1; UDS = 1'b1; RW = 1'b1;
    push({tag, "_idle"}, 4'hF, 1'b0, 1'b1, 1'b1, 1'b1, est);
    @(posedge CPU_CLK); #1 check();
  endtask
  task automatic do_reset(input string tag);
    @(negedge CPU_CLK);
    RESET = 1'b0;
    #1 push(tag, 4'hF, 1'b0, 1'b1, 1'b1, 1'b1, 2'b00);
    check();
    @(negedge CPU_CLK);
    RESET = 1'b1;
  endtask
  initial begin
    RESET = 1'b0; CPU_AS = 1'b1; RW = 1'b1; UDS = 1'b1; A = '0; D_IN = 4'h0;
    repeat (2) @(posedge CPU_CLK);
    #1 push("reset", 4'hF, 1'b0, 1'b1, 1'b1, 1'b1, 2'b00);
    check();
    @(negedge CPU_CLK);
    RESET = 1'b1;
    cyc(24'hE80000, 1, 0, "ram_rd00", 4'hE, 1, 0, 1, 1, 2'b00);
    cyc(24'hE80002, 1, 0, "ram_rd02", 4'h7, 1, 0, 1, 1, 2'b00);
    cyc(24'hE80004, 1, 0, "ram_rd04", 4'hF, 1, 0, 1, 1, 2'b00);
    cyc(24'hE80006, 1, 0, "ram_rd06", 4'hE, 1, 0, 1, 1, 2'b00);
    cyc(24'hE80008, 1, 0, "ram_rd08", 4'h3, 1, 0, 1, 1, 2'b00);
    cyc(24'hE80014, 1, 0, "ram_rd14", 4'h2, 1, 0, 1, 1, 2'b00);
    cyc(24'hE8001E, 1, 0, "ram_rd1e", 4'hF, 1, 0, 1, 1, 2'b00);
    cyc(24'hE80040, 1, 0, "ram_rd40", 4'hF, 1, 0, 1, 1, 2'b00);
    cyc(24'h200000, 1, 0, "pre_cfg_ram", 4'hF, 0, 1, 1, 1, 2'b00);
    cyc(24'hE80044, 0, 4'h2, "ignored_wr44", 4'hF, 0, 0, 1, 1, 2'b00);
    cyc(24'hE80048, 0, 4'h2, "ram_base_wr", 4'hF, 0, 0, 1, 1, 2'b01);
    cyc(24'h200000, 1, 0, "ram_hit", 4'hF, 0, 0, 0, 1, 2'b01);
    cyc(24'h3FFFFE, 0, 0, "ram_hit_wr", 4'hF, 0, 0, 0, 1, 2'b01);
    cyc(24'h400000, 1, 0, "ram_miss", 4'hF, 0, 1, 1, 1, 2'b01);
    cyc(24'hE80000, 1, 0, "ide_rd00", 4'hC, 1, 0, 1, 1, 2'b01);
    cyc(24'hE80006, 1, 0, "ide_rd06", 4'hD, 1, 0, 1, 1, 2'b01);
    cyc(24'hE8004A, 0, 4'h9, "ide_lo_wr", 4'hF, 0, 0, 1, 1, 2'b01);
    cyc(24'hE80048, 0, 4'hE, "ide_hi_wr", 4'hF, 0, 0, 1, 1, 2'b10);
    cyc(24'hE90000, 1, 0, "ide_hit", 4'hF, 0, 0, 1, 0, 2'b10);
    cyc(24'hE9FFFE, 1, 0, "ide_hit_top", 4'hF, 0, 0, 1, 0, 2'b10);
    cyc(24'hE80000, 1, 0, "window_closed", 4'hF, 0, 1, 1, 1, 2'b10);
    cyc(24'h100000, 1, 0, "ram_still_hit", 4'hF, 0, 0, 0, 1, 2'b10);
    do_reset("reset_between");
    cyc(24'hE8004C, 0, 4'h0, "shutup_ram", 4'hF, 0, 0, 1, 1, 2'b01);
    cyc(24'h000000, 1, 0, "shut_000000", 4'hF, 0, 1, 1, 1, 2'b01);
    cyc(24'h400000, 1, 0, "shut_400000", 4'hF, 0, 1, 1, 1, 2'b01);
    cyc(24'h800000, 1, 0, "shut_800000", 4'hF, 0, 1, 1, 1, 2'b01);
    cyc(24'hBFFFFE, 1, 0, "shut_bffffe", 4'hF, 0, 1, 1, 1, 2'b01);
    cyc(24'hE80000, 1, 0, "shut_ide_rd", 4'hC, 1, 0, 1, 1, 2'b01);
    do_reset("reset_before_hold");
    @(negedge CPU_CLK);
    A = 24'hE80048 >> 1; RW = 1'b0; D_IN = 4'h2; UDS = 1'b0; CPU_AS = 1'b0;
    for (int i = 0; i < 5; i++) begin
      push($sformatf("hold_wr_%0d", i), 4'hF, 1'b0, 1'b0, 1'b1, 1'b1, 2'b01);
      @(posedge CPU_CLK); #1 check();
    end
    @(negedge CPU_CLK);
    A = 24'hE80000 >> 1; RW = 1'b1;
    push("redecode", 4'hC, 1'b1, 1'b0, 1'b1, 1'b1, 2'b01);
    @(posedge CPU_CLK); #1 check();
    #2 RESET = 1'b0;
    #1 push("reset_mid_strobe", 4'hF, 1'b0, 1'b1, 1'b1, 1'b1, 2'b00);
    check();
    @(negedge CPU_CLK);
    CPU_AS = 1'b1; UDS = 1'b1; RESET = 1'b1;
    push("post_reset_idle", 4'hF, 1'b0, 1'b1, 1'b1, 1'b1, 2'b00);
    @(posedge CPU_CLK); #1 check();
    cyc(24'hE80000, 1, 0, "post_reset_rd", 4'hE, 1, 0, 1, 1, 2'b00);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
